// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, request/ready imem port and the IF/ID register feeding decode.
// Optional FETCH_PERF_CNT_EN adds fetch_count/stall_count performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazardDetectionInput,
  input  logic        BranchTaken,
  input  logic [31:0] branch_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_DISCARD = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] hold_instr_p0, hold_instr_d;
  logic [31:0] hold_pc4_p0, hold_pc4_d;
  logic [31:0] instr_p1, instr_d;
  logic [31:0] pc4_p1, pc4_d;
  logic        vld_p1, vld_d;
  logic        xfer;
  logic        new_avail;
  logic [31:0] new_instr;
  logic [31:0] new_pc4;
  logic [31:0] pc_inc;
  logic [31:0] target;

  function automatic logic [31:0] branch_target(input logic signed [31:0] pc4,
                                                input logic signed [31:0] off);
    logic signed [31:0] t;
    t = pc4 + (off <<< 2);
    return t;
  endfunction

  assign imem_req  = !rst && (state_q != S_HOLD);
  assign imem_addr = rst ? RESET_PC : pc_q;
  assign xfer      = imem_req && imem_ready;
  assign pc_inc    = pc_q + 32'd4;
  assign target    = branch_target(pc4_p1, branch_offset);

  // A fresh word for IF/ID comes either straight from memory or from the hold buffer.
  assign new_avail = ((state_q == S_REQ) && xfer) || (state_q == S_HOLD);
  assign new_instr = (state_q == S_HOLD) ? hold_instr_p0 : imem_rdata;
  assign new_pc4   = (state_q == S_HOLD) ? hold_pc4_p0 : pc_inc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    hold_instr_d = hold_instr_p0;
    hold_pc4_d   = hold_pc4_p0;
    instr_d      = 32'd0;
    pc4_d        = 32'd0;
    vld_d        = 1'b0;

    if (BranchTaken) begin
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      vld_d   = 1'b0;
    end else if (hazardDetectionInput) begin
      instr_d = instr_p1;
      pc4_d   = pc4_p1;
      vld_d   = vld_p1;
    end else if (new_avail) begin
      instr_d = new_instr;
      pc4_d   = new_pc4;
      vld_d   = 1'b1;
    end

    case (state_q)
      S_REQ: begin
        if (xfer) begin
          if (BranchTaken) begin
            pc_d = target;
          end else if (hazardDetectionInput) begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = pc_inc;
            pc_d         = pc_inc;
            state_d      = S_HOLD;
          end else begin
            pc_d = pc_inc;
          end
        end else if (BranchTaken) begin
          tgt_d   = target;
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        // The outstanding request must finish at its original address before redirecting.
        if (BranchTaken) begin
          tgt_d = target;
        end
        if (xfer) begin
          pc_d    = BranchTaken ? target : tgt_q;
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (BranchTaken) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (!hazardDetectionInput) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    tgt_q         <= tgt_d;
    hold_instr_p0 <= hold_instr_d;
    hold_pc4_p0   <= hold_pc4_d;
  end

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1 <= 32'd0;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
    end else begin
      instr_p1 <= instr_d;
      pc4_p1   <= pc4_d;
      vld_p1   <= vld_d;
    end
  end

  assign instruction = instr_p1;
  assign pc_plus4    = pc4_p1;
  assign valid       = vld_p1;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if ((state_q == S_REQ) && xfer && !BranchTaken) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (hazardDetectionInput || (imem_req && !imem_ready)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued per step and popped after the edge.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        hazardDetectionInput;
  logic        BranchTaken;
  logic [31:0] branch_offset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  fetch_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .hazardDetectionInput (hazardDetectionInput),
    .BranchTaken          (BranchTaken),
    .branch_offset        (branch_offset),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_rdata           (imem_rdata),
    .imem_ready           (imem_ready),
    .instruction          (instruction),
    .pc_plus4             (pc_plus4),
    .valid                (valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count          (fetch_count),
    .stall_count          (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns its own address as the instruction word.
  assign imem_rdata = imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic rdy, input logic hz,
                      input logic bt, input logic [31:0] off,
                      input logic exp_req, input logic [31:0] exp_addr,
                      input logic [31:0] ei, input logic [31:0] ep, input logic ev);
    exp_t e;
    rst                  = r;
    imem_ready           = rdy;
    hazardDetectionInput = hz;
    BranchTaken          = bt;
    branch_offset        = off;
    #1;
    check({tag, ".req"}, {31'd0, imem_req}, {31'd0, exp_req});
    check({tag, ".addr"}, imem_addr, exp_addr);
    e.instr = ei;
    e.pc4   = ep;
    e.vld   = ev;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, instruction);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".instr"}, instruction, e.instr);
      check({tag, ".pc4"}, pc_plus4, e.pc4);
      check({tag, ".valid"}, {31'd0, valid}, {31'd0, e.vld});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                  = 1'b1;
    imem_ready           = 1'b1;
    hazardDetectionInput = 1'b0;
    BranchTaken          = 1'b0;
    branch_offset        = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.instr", instruction, 32'd0);
    check("reset.pc4", pc_plus4, 32'd0);
    check("reset.valid", {31'd0, valid}, 32'd0);
    check("reset.req", {31'd0, imem_req}, 32'd0);
    check("reset.addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("reset.fetch_cnt", fetch_count, 32'd0);
    check("reset.stall_cnt", stall_count, 32'd0);
`endif

    // zero-wait stream
    for (int k = 0; k < 4; k++)
      step("stream", 0, 1, 0, 0, 0, 1, 4 * k, 4 * k, 4 * k + 4, 1);
`ifdef FETCH_PERF_CNT_EN
    check("stream.fetch_cnt", fetch_count, 32'd4);
    check("stream.stall_cnt", stall_count, 32'd0);
`endif

    // two wait cycles per fetch
    for (int w = 16; w <= 20; w += 4) begin
      step("wait", 0, 0, 0, 0, 0, 1, w, 0, 0, 0);
      step("wait", 0, 0, 0, 0, 0, 1, w, 0, 0, 0);
      step("wait_xfer", 0, 1, 0, 0, 0, 1, w, w, w + 4, 1);
    end
`ifdef FETCH_PERF_CNT_EN
    check("wait.fetch_cnt", fetch_count, 32'd6);
    check("wait.stall_cnt", stall_count, 32'd4);
`endif

    // hazard freeze for three cycles
    step("hz_pre", 0, 1, 0, 0, 0, 1, 24, 24, 28, 1);
    step("hz1", 0, 1, 1, 0, 0, 1, 28, 24, 28, 1);
    step("hz2", 0, 1, 1, 0, 0, 0, 32, 24, 28, 1);
    step("hz3", 0, 1, 1, 0, 0, 0, 32, 24, 28, 1);
    step("hz_rel", 0, 1, 0, 0, 0, 0, 32, 28, 32, 1);
    step("hz_next", 0, 1, 0, 0, 0, 1, 32, 32, 36, 1);

    // reset pulse, then stream up to pc_plus4 = 0x10 and take a backward branch
    step("rst_pulse", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      step("stream2", 0, 1, 0, 0, 0, 1, 4 * k, 4 * k, 4 * k + 4, 1);
    step("br", 0, 1, 0, 1, 32'hFFFF_FFFE, 1, 16, 0, 0, 0);
    step("br_tgt", 0, 1, 0, 0, 0, 1, 8, 8, 12, 1);

    // branch while the fetch of 0x20 is stalled
    for (int a = 12; a <= 28; a += 4)
      step("stream3", 0, 1, 0, 0, 0, 1, a, a, a + 4, 1);
    step("brst_bt", 0, 0, 0, 1, 5, 1, 32, 0, 0, 0);
    step("brst_wait", 0, 0, 0, 0, 0, 1, 32, 0, 0, 0);
    step("brst_drop", 0, 1, 0, 0, 0, 1, 32, 0, 0, 0);
    step("brst_tgt", 0, 1, 0, 0, 0, 1, 32'h34, 32'h34, 32'h38, 1);

    // reset while discarding
    step("disc_bt", 0, 0, 0, 1, 1, 1, 32'h38, 0, 0, 0);
    step("disc_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("disc_after", 0, 1, 0, 0, 0, 1, 0, 0, 4, 1);

    // reset while holding
    step("hold_in", 0, 1, 1, 0, 0, 1, 4, 0, 4, 1);
    step("hold_rst", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    check("hold_rst.fetch_cnt", fetch_count, 32'd0);
    check("hold_rst.stall_cnt", stall_count, 32'd0);
`endif
    step("hold_after", 0, 1, 0, 0, 0, 1, 0, 0, 4, 1);

    // PC wrap at the top of the address space
    step("wrap_bt", 0, 1, 0, 1, 32'hFFFF_FFFE, 1, 4, 0, 0, 0);
    step("wrap_top", 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1);
    step("wrap_zero", 0, 1, 0, 0, 0, 1, 0, 0, 4, 1);

    // branch and freeze together: branch wins
    step("bthz", 0, 1, 1, 1, 3, 1, 4, 0, 0, 0);
    step("bthz_tgt", 0, 1, 0, 0, 0, 1, 16, 16, 20, 1);

    // branch taken while in HOLD
    step("hbr_in", 0, 1, 1, 0, 0, 1, 20, 16, 20, 1);
    step("hbr_bt", 0, 1, 1, 1, 2, 0, 24, 0, 0, 0);
    step("hbr_tgt", 0, 1, 0, 0, 0, 1, 28, 28, 32, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
